// File: rtl/ibex_fp_pkg.sv
// Shared FPU issue-control types: op encoding, FSM states, op classes,
// exception flag bit positions and the canonical quiet NaN.
package ibex_fp_pkg;

    localparam int unsigned OP_W    = 5;
    localparam int unsigned RD_W    = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FLAGS_W = 5;
    localparam int unsigned LAT_W   = 4;
    localparam int unsigned TMO_W   = 10;

    // Exception flag bit positions within {NV,DZ,OF,UF,NX}
    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    localparam logic [DATA_W-1:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [OP_W-1:0] {
        FPU_NOP, FPU_ADD, FPU_SUB, FPU_MUL, FPU_MADD, FPU_MSUB, FPU_NMADD,
        FPU_NMSUB, FPU_DIV, FPU_SQRT, FPU_SGNJ, FPU_SGNJN, FPU_SGNJX,
        FPU_MIN, FPU_MAX, FPU_CMP_EQ, FPU_CMP_LT, FPU_CMP_LE, FPU_FCLASS,
        FPU_MOVE_X2F, FPU_MOVE_F2X, FPU_INT2FLOAT, FPU_INT2FLOAT_U,
        FPU_FLOAT2INT, FPU_FLOAT2INT_U
    } fpu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE, ST_EXEC, ST_WAIT_ITER, ST_RESP
    } issue_state_e;

    typedef enum logic [1:0] {
        OPC_NONE, OPC_SIMPLE, OPC_ARITH, OPC_ITER
    } op_class_e;

endpackage

// File: rtl/fpu_op_classify.sv
// Combinational op decoder: maps an FPU op to its latency class and the
// fixed latency used by the issue counter (0 for iterative / NOP).
//   op_i    : decoded FPU op
//   class_o : simple / arith / iterative / none
//   lat_o   : fixed result latency in cycles
module fpu_op_classify
    import ibex_fp_pkg::*;
#(
    parameter int unsigned LAT_ARITH = 3
) (
    input  fpu_op_e            op_i,
    output op_class_e          class_o,
    output logic [LAT_W-1:0]   lat_o
);

    always_comb begin
        class_o = OPC_NONE;
        lat_o   = '0;
        case (op_i)
            FPU_SGNJ, FPU_SGNJN, FPU_SGNJX, FPU_MIN, FPU_MAX,
            FPU_CMP_EQ, FPU_CMP_LT, FPU_CMP_LE, FPU_FCLASS,
            FPU_MOVE_X2F, FPU_MOVE_F2X: begin
                class_o = OPC_SIMPLE;
                lat_o   = LAT_W'(1);
            end
            FPU_ADD, FPU_SUB, FPU_MUL, FPU_MADD, FPU_MSUB, FPU_NMADD,
            FPU_NMSUB, FPU_INT2FLOAT, FPU_INT2FLOAT_U, FPU_FLOAT2INT,
            FPU_FLOAT2INT_U: begin
                class_o = OPC_ARITH;
                lat_o   = LAT_W'(LAT_ARITH);
            end
            FPU_DIV, FPU_SQRT: begin
                class_o = OPC_ITER;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: accepts one decoded op at a time, starts the
// datapath, waits a fixed latency (simple/arith) or for fpu_done_i
// (DIV/SQRT), holds the response until handshaked and accumulates flags.
// Optional macro FPU_ISSUE_TIMEOUT_EN: iterative ops that never signal
// done are force-completed after 1023 cycles with canonical NaN / NV.
// Ports:
//   clk_i, rst_i                     clock, sync active-high reset
//   req_valid_i/req_ready_o/op/rd    issue request
//   flush_i                          abort in-flight op or response
//   fpu_start_o/op_o/kill_o          datapath control
//   fpu_done_i/result_i/status_i     datapath completion/result
//   rsp_valid_o/ready_i/rd/result/status  response channel
//   busy_o, fflags_o, fflags_clr_i   status and accumulated flags
module fpu_issue_ctrl
    import ibex_fp_pkg::*;
#(
    parameter int unsigned LAT_ARITH = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  fpu_op_e             req_op_i,
    input  logic [RD_W-1:0]     req_rd_i,
    input  logic                flush_i,
    output logic                fpu_start_o,
    output fpu_op_e             fpu_op_o,
    output logic                fpu_kill_o,
    input  logic                fpu_done_i,
    input  logic [DATA_W-1:0]   fpu_result_i,
    input  logic [FLAGS_W-1:0]  fpu_status_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [RD_W-1:0]     rsp_rd_o,
    output logic [DATA_W-1:0]   rsp_result_o,
    output logic [FLAGS_W-1:0]  rsp_status_o,
    output logic                busy_o,
    output logic [FLAGS_W-1:0]  fflags_o,
    input  logic                fflags_clr_i
);

    issue_state_e         state_q, state_d;
    logic [LAT_W-1:0]     cnt_q, cnt_d;
    fpu_op_e              op_q, op_d;
    logic [RD_W-1:0]      rd_q, rd_d;
    logic                 start_q, start_d;
    logic [DATA_W-1:0]    res_q, res_d;
    logic [FLAGS_W-1:0]   sts_q, sts_d;
    logic [FLAGS_W-1:0]   fflags_q, fflags_d;
    logic                 kill_c;
    logic                 accept_c;
    op_class_e            cls_c;
    logic [LAT_W-1:0]     lat_c;

`ifdef FPU_ISSUE_TIMEOUT_EN
    logic [TMO_W-1:0]     tmo_q, tmo_d;
`endif

    fpu_op_classify #(.LAT_ARITH(LAT_ARITH)) u_classify (
        .op_i    (req_op_i),
        .class_o (cls_c),
        .lat_o   (lat_c)
    );

    // A flush in IDLE blocks acceptance for that cycle
    assign req_ready_o = (state_q == ST_IDLE) & ~flush_i;
    assign accept_c    = req_valid_i & req_ready_o;

    // Next-state / datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        start_d  = 1'b0;
        res_d    = res_q;
        sts_d    = sts_q;
        fflags_d = fflags_q;
        kill_c   = 1'b0;
`ifdef FPU_ISSUE_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // NOP handshakes are consumed silently
                if (accept_c && (req_op_i != FPU_NOP)) begin
                    op_d    = req_op_i;
                    rd_d    = req_rd_i;
                    start_d = 1'b1;
                    cnt_d   = lat_c;
`ifdef FPU_ISSUE_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                    state_d = (cls_c == OPC_ITER) ? ST_WAIT_ITER : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (flush_i) begin
                    kill_c  = 1'b1;
                    cnt_d   = '0;
                    op_d    = FPU_NOP;
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    res_d   = fpu_result_i;
                    sts_d   = fpu_status_i;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q - LAT_W'(1);
                end
            end
            ST_WAIT_ITER: begin
                // done in the start cycle itself is illegal and ignored
                if (flush_i) begin
                    kill_c  = 1'b1;
                    op_d    = FPU_NOP;
                    state_d = ST_IDLE;
                end else if (fpu_done_i && !start_q) begin
                    res_d   = fpu_result_i;
                    sts_d   = fpu_status_i;
                    state_d = ST_RESP;
`ifdef FPU_ISSUE_TIMEOUT_EN
                end else if (tmo_q == {TMO_W{1'b1}}) begin
                    res_d          = CANON_NAN;
                    sts_d          = '0;
                    sts_d[FLAG_NV] = 1'b1;
                    kill_c         = 1'b1;
                    state_d        = ST_RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
`endif
                end
            end
            ST_RESP: begin
                if (flush_i) begin
                    op_d    = FPU_NOP;
                    state_d = ST_IDLE;
                end else if (rsp_ready_i) begin
                    fflags_d = fflags_q | sts_q;
                    op_d     = FPU_NOP;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (fflags_clr_i) begin
            fflags_d = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= FPU_NOP;
            rd_q     <= '0;
            start_q  <= 1'b0;
            res_q    <= '0;
            sts_q    <= '0;
            fflags_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            start_q  <= start_d;
            res_q    <= res_d;
            sts_q    <= sts_d;
            fflags_q <= fflags_d;
        end
    end

`ifdef FPU_ISSUE_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // Reset discards the op without signalling a kill to the datapath
    assign fpu_kill_o   = kill_c & ~rst_i;
    assign fpu_start_o  = start_q;
    assign fpu_op_o     = op_q;
    assign rsp_valid_o  = (state_q == ST_RESP);
    assign rsp_rd_o     = rd_q;
    assign rsp_result_o = res_q;
    assign rsp_status_o = sts_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign fflags_o     = fflags_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl with a cycle-level reference model.
module tb_fpu_issue_ctrl;
    import ibex_fp_pkg::*;

    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        rst_i, req_valid_i, flush_i, fpu_done_i, rsp_ready_i, fflags_clr_i;
    logic        req_ready_o, fpu_start_o, fpu_kill_o, rsp_valid_o, busy_o;
    fpu_op_e     req_op_i, fpu_op_o;
    logic [4:0]  req_rd_i, rsp_rd_o, fpu_status_i, rsp_status_o, fflags_o;
    logic [31:0] fpu_result_i, rsp_result_o;

    int total = 0;
    int bad   = 0;
    logic [4:0] fflags_m;

    always #5 clk = ~clk;

    fpu_issue_ctrl #(.LAT_ARITH(LAT)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_rd_i(req_rd_i), .flush_i(flush_i),
        .fpu_start_o(fpu_start_o), .fpu_op_o(fpu_op_o), .fpu_kill_o(fpu_kill_o),
        .fpu_done_i(fpu_done_i), .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rd_o(rsp_rd_o),
        .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o),
        .busy_o(busy_o), .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i)
    );

    // Reference latency: cycles from start to capture
    function automatic int exp_cap(input fpu_op_e op, input int done_dly);
        case (op)
            FPU_DIV, FPU_SQRT: return done_dly;
            FPU_ADD, FPU_SUB, FPU_MUL, FPU_MADD, FPU_MSUB, FPU_NMADD, FPU_NMSUB,
            FPU_INT2FLOAT, FPU_INT2FLOAT_U, FPU_FLOAT2INT, FPU_FLOAT2INT_U: return LAT;
            default: return 1;
        endcase
    endfunction

    function automatic bit is_iter(input fpu_op_e op);
        return (op == FPU_DIV) || (op == FPU_SQRT);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst_i = 1'b0; req_valid_i = 1'b0; req_op_i = FPU_NOP; req_rd_i = '0;
        flush_i = 1'b0; fpu_done_i = 1'b0; fpu_result_i = '0; fpu_status_i = '0;
        rsp_ready_i = 1'b0; fflags_clr_i = 1'b0;
    endtask

    // Full transaction: accept, execute, response with ready_wait stall cycles
    task automatic do_op(input fpu_op_e op, input logic [4:0] rd, input logic [31:0] res,
                         input logic [4:0] st, input int done_dly, input int ready_wait,
                         input bit clr_hs);
        int cap;
        cap = exp_cap(op, done_dly);
        req_valid_i = 1'b1; req_op_i = op; req_rd_i = rd;
        #1;
        total++;
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL accept_ready op=%s got=%b exp=1", op.name(), req_ready_o); end
        tick();
        for (int c = 0; c <= cap; c++) begin
            // keep a competing request pending: it must not be accepted
            req_valid_i  = 1'b1;
            req_op_i     = fpu_op_e'(5'($urandom_range(1, 24)));
            fpu_done_i   = is_iter(op) ? ((c == cap) || (c == 0)) : 1'($urandom_range(0, 1));
            fpu_result_i = (c == cap) ? res : $urandom;
            fpu_status_i = (c == cap) ? st : 5'($urandom);
            #1;
            total++;
            if (fpu_start_o !== (c == 0)) begin bad++; $display("FAIL start op=%s c=%0d got=%b", op.name(), c, fpu_start_o); end
            total++;
            if (fpu_op_o !== op) begin bad++; $display("FAIL op_hold c=%0d got=%s exp=%s", c, fpu_op_o.name(), op.name()); end
            total++;
            if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0 || busy_o !== 1'b1 || fpu_kill_o !== 1'b0) begin
                bad++; $display("FAIL exec_flags op=%s c=%0d valid=%b ready=%b busy=%b kill=%b", op.name(), c, rsp_valid_o, req_ready_o, busy_o, fpu_kill_o);
            end
            tick();
        end
        req_valid_i = 1'b0; req_op_i = FPU_NOP;
        for (int j = 0; j <= ready_wait; j++) begin
            rsp_ready_i  = (j == ready_wait);
            fflags_clr_i = clr_hs && (j == ready_wait);
            fpu_done_i   = 1'($urandom_range(0, 1));
            fpu_result_i = $urandom;
            fpu_status_i = 5'($urandom);
            #1;
            total++;
            if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0) begin bad++; $display("FAIL rsp_valid op=%s j=%0d valid=%b ready=%b", op.name(), j, rsp_valid_o, req_ready_o); end
            total++;
            if (rsp_rd_o !== rd || rsp_result_o !== res || rsp_status_o !== st) begin
                bad++; $display("FAIL rsp_data op=%s j=%0d rd=%0d/%0d res=%h/%h st=%b/%b", op.name(), j, rsp_rd_o, rd, rsp_result_o, res, rsp_status_o, st);
            end
            if (j == ready_wait) fflags_m = clr_hs ? 5'b0 : (fflags_m | st);
            tick();
        end
        rsp_ready_i = 1'b0; fflags_clr_i = 1'b0; fpu_done_i = 1'b0;
        #1;
        total++;
        if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 1'b1 || fpu_op_o !== FPU_NOP) begin
            bad++; $display("FAIL back_idle op=%s valid=%b busy=%b ready=%b fop=%s", op.name(), rsp_valid_o, busy_o, req_ready_o, fpu_op_o.name());
        end
        total++;
        if (fflags_o !== fflags_m) begin bad++; $display("FAIL fflags op=%s got=%b exp=%b", op.name(), fflags_o, fflags_m); end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick(); tick();
        total++;
        if (fpu_start_o !== 0 || fpu_kill_o !== 0 || fpu_op_o !== FPU_NOP || rsp_valid_o !== 0 || busy_o !== 0) begin
            bad++; $display("FAIL reset_ctrl start=%b kill=%b op=%s valid=%b busy=%b", fpu_start_o, fpu_kill_o, fpu_op_o.name(), rsp_valid_o, busy_o);
        end
        total++;
        if (rsp_rd_o !== 0 || rsp_result_o !== 0 || rsp_status_o !== 0 || fflags_o !== 0) begin
            bad++; $display("FAIL reset_data rd=%0d res=%h st=%b ff=%b", rsp_rd_o, rsp_result_o, rsp_status_o, fflags_o);
        end
        rst_i = 1'b0;
        fflags_m = '0;
        tick();
    endtask

    task automatic test_nop();
        req_valid_i = 1'b1; req_op_i = FPU_NOP; req_rd_i = 5'd3;
        #1;
        total++;
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL nop_ready got=%b exp=1", req_ready_o); end
        tick();
        req_valid_i = 1'b0;
        #1;
        total++;
        if (fpu_start_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 1'b1) begin
            bad++; $display("FAIL nop_effect start=%b busy=%b ready=%b", fpu_start_o, busy_o, req_ready_o);
        end
        tick();
    endtask

    task automatic test_directed();
        do_op(FPU_ADD, 5'd7, 32'h4040_0000, 5'b00000, 0, 0, 1'b0);
        do_op(FPU_SGNJ, 5'd2, 32'hBF80_0000, 5'b00000, 0, 3, 1'b0);
        do_op(FPU_DIV, 5'd9, 32'h3EAA_AAAB, 5'b01000, 12, 0, 1'b0);
        total++;
        if (fflags_o !== 5'b01000) begin bad++; $display("FAIL div_flags got=%b exp=01000", fflags_o); end
        do_op(FPU_MUL, 5'd4, 32'h4100_0000, 5'b00001, 0, 1, 1'b0);
        total++;
        if (fflags_o !== 5'b01001) begin bad++; $display("FAIL nx_accum got=%b exp=01001", fflags_o); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            do_op(fpu_op_e'(5'($urandom_range(1, 24))), 5'($urandom), $urandom, 5'($urandom),
                  int'($urandom_range(1, 20)), int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
        end
    endtask

    task automatic test_clear();
        fflags_clr_i = 1'b1;
        tick();
        fflags_clr_i = 1'b0;
        fflags_m = '0;
        #1;
        total++;
        if (fflags_o !== 5'b0) begin bad++; $display("FAIL flag_clear got=%b exp=0", fflags_o); end
        // clear coinciding with a response handshake wins
        do_op(FPU_MAX, 5'd1, 32'h1234_5678, 5'b10101, 0, 0, 1'b1);
    endtask

    // Flush fl cycles after start while busy
    task automatic flush_busy(input fpu_op_e op, input int fl);
        req_valid_i = 1'b1; req_op_i = op; req_rd_i = 5'd11;
        tick();
        req_valid_i = 1'b0;
        for (int c = 0; c <= fl; c++) begin
            flush_i    = (c == fl);
            fpu_done_i = 1'b0;
            #1;
            total++;
            if (fpu_kill_o !== (c == fl)) begin bad++; $display("FAIL kill op=%s c=%0d got=%b", op.name(), c, fpu_kill_o); end
            tick();
        end
        flush_i = 1'b0;
        #1;
        total++;
        if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0 || fpu_kill_o !== 1'b0 || fpu_op_o !== FPU_NOP || fflags_o !== fflags_m) begin
            bad++; $display("FAIL post_flush op=%s busy=%b valid=%b kill=%b ff=%b/%b", op.name(), busy_o, rsp_valid_o, fpu_kill_o, fflags_o, fflags_m);
        end
        tick();
        total++;
        if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL flush_no_rsp op=%s got=%b", op.name(), rsp_valid_o); end
    endtask

    task automatic test_flush();
        flush_busy(FPU_SQRT, 4);
        for (int i = 0; i < 4; i++) begin
            fpu_op_e op;
            op = fpu_op_e'(5'($urandom_range(1, 24)));
            flush_busy(op, is_iter(op) ? int'($urandom_range(0, 30)) : int'($urandom_range(0, exp_cap(op, 0))));
        end
        // flush while the response is pending drops it
        req_valid_i = 1'b1; req_op_i = FPU_SUB; req_rd_i = 5'd6;
        tick();
        req_valid_i = 1'b0;
        for (int c = 0; c <= int'(LAT); c++) begin
            fpu_status_i = 5'b11111;
            tick();
        end
        total++;
        if (rsp_valid_o !== 1'b1) begin bad++; $display("FAIL resp_reach got=%b exp=1", rsp_valid_o); end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        total++;
        if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || fflags_o !== fflags_m) begin
            bad++; $display("FAIL resp_flush valid=%b busy=%b ff=%b/%b", rsp_valid_o, busy_o, fflags_o, fflags_m);
        end
        // flush in IDLE blocks acceptance
        req_valid_i = 1'b1; req_op_i = FPU_ADD; flush_i = 1'b1;
        #1;
        total++;
        if (req_ready_o !== 1'b0) begin bad++; $display("FAIL idle_flush_ready got=%b exp=0", req_ready_o); end
        tick();
        req_valid_i = 1'b0; flush_i = 1'b0;
        #1;
        total++;
        if (fpu_start_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL idle_flush_accept start=%b busy=%b", fpu_start_o, busy_o); end
    endtask

    task automatic test_reset_mid();
        do_op(FPU_FCLASS, 5'd30, 32'hDEAD_BEEF, 5'b00110, 0, 0, 1'b0);
        req_valid_i = 1'b1; req_op_i = FPU_MUL; req_rd_i = 5'd17;
        tick();
        req_valid_i = 1'b0; req_op_i = FPU_NOP;
        rst_i = 1'b1; flush_i = 1'b1;
        #1;
        total++;
        if (fpu_kill_o !== 1'b0) begin bad++; $display("FAIL reset_kill got=%b exp=0", fpu_kill_o); end
        tick();
        rst_i = 1'b0; flush_i = 1'b0;
        #1;
        total++;
        if (fpu_start_o !== 0 || fpu_op_o !== FPU_NOP || rsp_valid_o !== 0 || busy_o !== 0 ||
            rsp_rd_o !== 0 || rsp_result_o !== 0 || rsp_status_o !== 0 || fflags_o !== 0) begin
            bad++; $display("FAIL reset_mid start=%b op=%s valid=%b busy=%b rd=%0d res=%h st=%b ff=%b",
                            fpu_start_o, fpu_op_o.name(), rsp_valid_o, busy_o, rsp_rd_o, rsp_result_o, rsp_status_o, fflags_o);
        end
        fflags_m = '0;
        tick();
    endtask

`ifdef FPU_ISSUE_TIMEOUT_EN
    task automatic test_timeout();
        int errs;
        errs = 0;
        req_valid_i = 1'b1; req_op_i = FPU_DIV; req_rd_i = 5'd21;
        tick();
        req_valid_i = 1'b0;
        for (int c = 0; c <= 1023; c++) begin
            #1;
            if (fpu_kill_o !== (c == 1023) || rsp_valid_o !== 1'b0) errs++;
            tick();
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL timeout_wait errors=%0d exp=0", errs); end
        #1;
        total++;
        if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'h7FC0_0000 || rsp_status_o !== 5'b10000) begin
            bad++; $display("FAIL timeout_rsp valid=%b res=%h st=%b", rsp_valid_o, rsp_result_o, rsp_status_o);
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        fflags_m = fflags_m | 5'b10000;
        #1;
        total++;
        if (fflags_o !== fflags_m || busy_o !== 1'b0) begin bad++; $display("FAIL timeout_flags ff=%b/%b busy=%b", fflags_o, fflags_m, busy_o); end
    endtask
`else
    task automatic test_timeout();
        int errs;
        errs = 0;
        req_valid_i = 1'b1; req_op_i = FPU_DIV; req_rd_i = 5'd21;
        tick();
        req_valid_i = 1'b0;
        for (int c = 0; c < 1100; c++) begin
            #1;
            if (rsp_valid_o !== 1'b0 || busy_o !== 1'b1 || fpu_kill_o !== 1'b0) errs++;
            tick();
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL wait_forever errors=%0d exp=0", errs); end
        flush_i = 1'b1;
        #1;
        total++;
        if (fpu_kill_o !== 1'b1) begin bad++; $display("FAIL wait_flush_kill got=%b exp=1", fpu_kill_o); end
        tick();
        flush_i = 1'b0;
        #1;
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL wait_flush_idle busy=%b exp=0", busy_o); end
    endtask
`endif

    initial begin
        fflags_m = '0;
        test_reset();
        test_nop();
        test_directed();
        test_random();
        test_clear();
        test_flush();
        test_reset_mid();
        test_timeout();
        do_op(FPU_ADD, 5'd7, 32'h4040_0000, 5'b00100, 0, 0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter LAT_ARITH, default 3, fixed result latency in cycles for ADD/SUB/MUL/MADD/MSUB/NMADD/NMSUB/INT2FLOAT(_U)/FLOAT2INT(_U); legal range 2..15.
REQ-002 SHALL have these ports: clk_i  in  1  clock; one clock domain, all logic on rising edge.
REQ-003 rst_i  in  1  reset; synchronous, active-high.
REQ-004 req_valid_i in 1 request valid; req_ready_o out 1 accepting; req_op_i in fpu_op_e decoded FPU op; req_rd_i in 5 destination register.
REQ-005 flush_i in 1 abort the in-flight op.
REQ-006 fpu_start_o out 1 one-cycle datapath start; fpu_op_o out fpu_op_e op held for the whole operation; fpu_kill_o out 1 datapath abort.
REQ-007 fpu_done_i in 1 completion from the iterative unit (DIV/SQRT); fpu_result_i in 32 result; fpu_status_i in 5 exception flags {NV,DZ,OF,UF,NX}.
REQ-008 rsp_valid_o out 1; rsp_ready_i in 1; rsp_rd_o out 5; rsp_result_o out 32; rsp_status_o out 5.
REQ-009 busy_o out 1 state not IDLE; fflags_o out 5 accumulated flags; fflags_clr_i in 1 clear accumulated flags.

Function
REQ-010 SHALL implement states IDLE, EXEC, WAIT_ITER, RESP.
REQ-011 req_ready_o SHALL be 1 only in IDLE; a handshake is req_valid_i & req_ready_o.
REQ-012 Handshake with req_op_i == FPU_NOP SHALL be consumed with no start, no response; state stays IDLE.
REQ-013 Other handshake in cycle T SHALL latch op/rd; fpu_start_o = 1 in T+1 only; fpu_op_o = latched op from T+1 until return to IDLE (FPU_NOP in IDLE).
REQ-014 Op classes: simple (SGNJ*, MIN, MAX, CMP_*, FCLASS, MOVE_*) latency 1; arith latency LAT_ARITH; iterative (DIV, SQRT) latency set by fpu_done_i.
REQ-015 Simple/arith: state EXEC; 4-bit down-counter loaded with latency at start; result/status captured in cycle start+latency; state RESP next cycle.
REQ-016 Iterative: state WAIT_ITER from start cycle; capture on first cycle with fpu_done_i = 1 (including start cycle is illegal, ignored); RESP next cycle.
REQ-017 fpu_done_i outside WAIT_ITER SHALL be ignored.
REQ-018 In RESP, rsp_valid_o = 1 with rsp_rd_o/rsp_result_o/rsp_status_o stable until rsp_valid_o & rsp_ready_i; then IDLE next cycle (no same-cycle accept, back-to-back issue spacing >= 1 IDLE cycle).
REQ-019 flush_i in EXEC or WAIT_ITER SHALL assert fpu_kill_o for that cycle, discard the op, enter IDLE next cycle, no response, no flag update.
REQ-020 flush_i in RESP SHALL drop the response (rsp_valid_o 0 next cycle, IDLE); flush_i in IDLE SHALL block acceptance that cycle.
REQ-021 On response handshake fflags_o SHALL OR in rsp_status_o; fflags_clr_i same cycle SHALL win (result 0).

Reset
REQ-022 rst_i SHALL, at the next edge, force IDLE, counter 0, fpu_start_o 0, fpu_kill_o 0, fpu_op_o FPU_NOP, rsp_valid_o 0, rsp_rd_o 0, rsp_result_o 0, rsp_status_o 0, fflags_o 0, busy_o 0.
REQ-023 Reset mid-operation SHALL discard the op without asserting fpu_kill_o; datapath is reset by the same rst_i.

Configuration
REQ-024 Macro FPU_ISSUE_TIMEOUT_EN: when defined, a 10-bit counter in WAIT_ITER forces capture after 1023 cycles without fpu_done_i, with result 32'h7FC00000, status NV, fpu_kill_o pulsed that cycle.
REQ-025 Without FPU_ISSUE_TIMEOUT_EN the block SHALL wait in WAIT_ITER indefinitely (flush_i/rst_i only exits).

Structure
REQ-026 Shared package ibex_fp_pkg SHALL hold fpu_op_e, the state enum, the op-class enum, flag bit indices and the canonical NaN constant.
REQ-027 One sub-module fpu_op_classify (combinational fpu_op_e -> class and latency) SHALL be instantiated.

Verification
REQ-028 FPU_ADD, LAT_ARITH=3, accept T -> start T+1, capture T+4, rsp_valid_o T+5, fpu_result_i 32'h40400000 returned with rd 5'd7.
REQ-029 FPU_SGNJ accept T -> rsp_valid_o T+3; rsp_ready_i held 0 three cycles -> outputs stable, req_ready_o 0 throughout.
REQ-030 FPU_DIV, fpu_done_i at start+12 status 5'b01000 -> rsp_status_o 5'b01000, fflags_o 5'b01000 after handshake; second op NX -> 5'b01001.
REQ-031 FPU_SQRT, flush_i at start+4 -> fpu_kill_o 1 that cycle, IDLE next, no rsp_valid_o, fflags_o unchanged.
REQ-032 rst_i during EXEC -> all outputs at reset values next cycle; FPU_NOP request -> req_ready_o stays 1, no fpu_start_o.
REQ-033 With FPU_ISSUE_TIMEOUT_EN, FPU_DIV without fpu_done_i -> response at start+1024 with 32'h7FC00000, status 5'b10000.
